input_matrix_loader: RTL and testbench

INPUT_MATRIX_LOADER -- requirements
Module: input_matrix_loader

---
 rtl/input_matrix_loader_pkg.sv | 49 ++++
 rtl/input_matrix_loader_if.sv | 31 +++
 rtl/input_matrix_loader_line_packer.sv | 51 +++++
 rtl/input_matrix_loader.sv | 94 +++++++++
 tb/tb_input_matrix_loader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/input_matrix_loader_pkg.sv
// Shared sizing, derived line geometry and FSM state type for the input-matrix loader.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 32
`endif

package input_matrix_loader_pkg;

   localparam int ROWS           = `ROWS;
   localparam int COLS           = `COLS;
   localparam int WORD_SIZE      = `WORD_SIZE;
   localparam int MEM_PORT_WIDTH = `MEM_PORT_WIDTH;

   function automatic int calc_wpl(input int mem_w, input int word_w);
      return mem_w / word_w;
   endfunction

   function automatic int calc_words(input int rows, input int cols);
      return 2 * rows * cols;
   endfunction

   function automatic int calc_lines(input int words, input int wpl);
      return (words + wpl - 1) / wpl;
   endfunction

   localparam int WPL = calc_wpl(MEM_PORT_WIDTH, WORD_SIZE);
   localparam int N   = calc_words(ROWS, COLS);
   localparam int L   = calc_lines(N, WPL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_KICK,
      S_WAIT_RDY,
      S_MATMUL,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/input_matrix_loader_if.sv
// Host stream, input-RAM write port and matmul-FSM handshake of the loader.
interface input_matrix_loader_if #(
   parameter int WORD_SIZE      = input_matrix_loader_pkg::WORD_SIZE,
   parameter int MEM_PORT_WIDTH = input_matrix_loader_pkg::MEM_PORT_WIDTH
);
   logic                      load_start;
   logic                      host_valid;
   logic                      host_ready;
   logic [WORD_SIZE-1:0]      host_data;
   logic                      host_last;
   logic [31:0]               mem_addr;
   logic                      mem_wr_en;
   logic [MEM_PORT_WIDTH-1:0] mem_wr_data;
   logic                      inputs_rdy;
   logic                      start_fsm;
   logic                      start_matmul;
   logic                      fsm_rdy;
   logic                      load_err;

   modport master (
      output load_start, host_valid, host_data, host_last, fsm_rdy,
      input  host_ready, mem_addr, mem_wr_en, mem_wr_data,
             inputs_rdy, start_fsm, start_matmul, load_err
   );

   modport slave (
      input  load_start, host_valid, host_data, host_last, fsm_rdy,
      output host_ready, mem_addr, mem_wr_en, mem_wr_data,
             inputs_rdy, start_fsm, start_matmul, load_err
   );
endinterface

// File: rtl/input_matrix_loader_line_packer.sv
// Packs accepted words LSB-first into RAM lines; a forced close emits a partial line zero-filled above.
module line_packer
   import input_matrix_loader_pkg::*;
#(
   parameter int WORD_SIZE = input_matrix_loader_pkg::WORD_SIZE,
   parameter int WPL       = input_matrix_loader_pkg::WPL
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     word_vld,
   input  logic [WORD_SIZE-1:0]     word_data,
   input  logic                     word_end,
   output logic                     line_vld,
   output logic [WPL*WORD_SIZE-1:0] line_data
);
   localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;

   logic [WPL*WORD_SIZE-1:0] line_p0;
   logic [WPL*WORD_SIZE-1:0] line_nxt;
   logic [IDX_W-1:0]         idx_p0;
   logic                     line_close;

   always_comb begin
      line_nxt = line_p0;
      for (int k = 0; k < WPL; k++) begin
         if (idx_p0 == IDX_W'(k)) line_nxt[k*WORD_SIZE +: WORD_SIZE] = word_data;
      end
   end

   assign line_close = word_vld && (word_end || (idx_p0 == IDX_W'(WPL - 1)));

   // p0 accumulates the open line; the closed line is presented one cycle after its last word
   always_ff @(posedge clk) begin
      if (rst) begin
         line_p0   <= '0;
         idx_p0    <= '0;
         line_vld  <= 1'b0;
         line_data <= '0;
      end else begin
         line_vld <= line_close;
         if (line_close) begin
            line_data <= line_nxt;
            line_p0   <= '0;
            idx_p0    <= '0;
         end else if (word_vld) begin
            line_p0 <= line_nxt;
            idx_p0  <= idx_p0 + IDX_W'(1);
         end
      end
   end
endmodule

// File: rtl/input_matrix_loader.sv
// Streams the top and left matrices from the host into input RAM, then kicks the matmul FSM.
module input_matrix_loader
   import input_matrix_loader_pkg::*;
#(
   parameter int          ROWS           = `ROWS,
   parameter int          COLS           = `COLS,
   parameter int          WORD_SIZE      = `WORD_SIZE,
   parameter int          MEM_PORT_WIDTH = `MEM_PORT_WIDTH,
   parameter logic [31:0] BASE_ADDR      = 32'd0
) (
   input logic                  clk,
   input logic                  rst,
   input_matrix_loader_if.slave bus
);
   localparam int LINE_WORDS  = calc_wpl(MEM_PORT_WIDTH, WORD_SIZE);
   localparam int TOTAL_WORDS = calc_words(ROWS, COLS);
   localparam int CNT_W       = $clog2(TOTAL_WORDS + 1);

   state_t           state_p0;
   state_t           state_nxt;
   logic [CNT_W-1:0] word_cnt_p0;
   logic [31:0]      line_addr_p0;
   logic             inputs_rdy_p0;
   logic             load_err_p0;
   logic             hs;
   logic             last_word;
   logic             start_load;

   assign hs         = bus.host_valid && (state_p0 == S_LOAD);
   assign last_word  = (word_cnt_p0 == CNT_W'(TOTAL_WORDS - 1));
   assign start_load = bus.load_start && ((state_p0 == S_IDLE) || (state_p0 == S_DONE));

   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         S_IDLE, S_DONE: if (bus.load_start) state_nxt = S_LOAD;
         S_LOAD: begin
            // a misplaced last flag in either direction is unrecoverable
            if (hs) begin
               if (bus.host_last != last_word) state_nxt = S_ERR;
               else if (last_word)             state_nxt = S_FLUSH;
            end
         end
         S_FLUSH:    state_nxt = S_KICK;
         S_KICK:     state_nxt = S_WAIT_RDY;
         S_WAIT_RDY: if (bus.fsm_rdy) state_nxt = S_MATMUL;
         S_MATMUL:   state_nxt = S_DONE;
         S_ERR:      state_nxt = S_ERR;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0      <= S_IDLE;
         word_cnt_p0   <= '0;
         line_addr_p0  <= BASE_ADDR;
         inputs_rdy_p0 <= 1'b0;
         load_err_p0   <= 1'b0;
      end else begin
         state_p0 <= state_nxt;
         if (start_load) begin
            word_cnt_p0   <= '0;
            line_addr_p0  <= BASE_ADDR;
            inputs_rdy_p0 <= 1'b0;
         end else begin
            if (hs)            word_cnt_p0  <= word_cnt_p0 + CNT_W'(1);
            if (bus.mem_wr_en) line_addr_p0 <= line_addr_p0 + 32'd1;
         end
         if (state_p0 == S_FLUSH)  inputs_rdy_p0 <= 1'b1;
         if (state_nxt == S_ERR)   load_err_p0   <= 1'b1;
      end
   end

   line_packer #(
      .WORD_SIZE (WORD_SIZE),
      .WPL       (LINE_WORDS)
   ) u_line_packer (
      .clk       (clk),
      .rst       (rst),
      .word_vld  (hs),
      .word_data (bus.host_data),
      .word_end  (last_word || bus.host_last),
      .line_vld  (bus.mem_wr_en),
      .line_data (bus.mem_wr_data)
   );

   assign bus.host_ready   = (state_p0 == S_LOAD);
   assign bus.start_fsm    = (state_p0 == S_KICK);
   assign bus.start_matmul = (state_p0 == S_MATMUL);
   assign bus.mem_addr     = line_addr_p0;
   assign bus.inputs_rdy   = inputs_rdy_p0;
   assign bus.load_err     = load_err_p0;
endmodule

// File: tb/tb_input_matrix_loader.sv
// Directed bench: a 32-bit-line and a 24-bit-line loader driven by the same host stream.
module tb_input_matrix_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   input_matrix_loader_if #(.WORD_SIZE(8), .MEM_PORT_WIDTH(32)) ifa ();
   input_matrix_loader_if #(.WORD_SIZE(8), .MEM_PORT_WIDTH(24)) ifb ();

   assign ifb.load_start = ifa.load_start;
   assign ifb.host_valid = ifa.host_valid;
   assign ifb.host_data  = ifa.host_data;
   assign ifb.host_last  = ifa.host_last;
   assign ifb.fsm_rdy    = ifa.fsm_rdy;

   input_matrix_loader #(.ROWS(4), .COLS(4), .WORD_SIZE(8), .MEM_PORT_WIDTH(32), .BASE_ADDR(32'd0))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   input_matrix_loader #(.ROWS(4), .COLS(4), .WORD_SIZE(8), .MEM_PORT_WIDTH(24), .BASE_ADDR(32'd0))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));

   int passed = 0;
   int total  = 0;
   int n_start_fsm = 0;
   int n_start_matmul = 0;
   logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];

   typedef struct {
      int          dut;
      int          line;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_vec_t;
   wr_vec_t vecs[12];

   always @(negedge clk) begin
      if (ifa.mem_wr_en) begin
         qa_addr.push_back(ifa.mem_addr);
         qa_data.push_back(ifa.mem_wr_data);
      end
      if (ifb.mem_wr_en) begin
         qb_addr.push_back(ifb.mem_addr);
         qb_data.push_back(32'(ifb.mem_wr_data));
      end
      if (ifa.start_fsm)    n_start_fsm    <= n_start_fsm + 1;
      if (ifa.start_matmul) n_start_matmul <= n_start_matmul + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_queues();
      qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
   endtask

   task automatic pulse_load_start();
      ifa.load_start = 1'b1;
      @(negedge clk);
      ifa.load_start = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] val, input logic last);
      int guard;
      guard = 0;
      ifa.host_valid = 1'b1;
      ifa.host_data  = val;
      ifa.host_last  = last;
      while (ifa.host_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("host_ready_timeout", 64'(ifa.host_ready), 64'd1);
      @(negedge clk);
      ifa.host_valid = 1'b0;
      ifa.host_last  = 1'b0;
   endtask

   task automatic verify_table(input string tag);
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, d;
         int          sz;
         sz = (vecs[i].dut == 0) ? qa_addr.size() : qb_addr.size();
         if (vecs[i].line < sz) begin
            a = (vecs[i].dut == 0) ? qa_addr[vecs[i].line] : qb_addr[vecs[i].line];
            d = (vecs[i].dut == 0) ? qa_data[vecs[i].line] : qb_data[vecs[i].line];
            check($sformatf("%s_dut%0d_line%0d_addr", tag, vecs[i].dut, vecs[i].line), 64'(a), 64'(vecs[i].addr));
            check($sformatf("%s_dut%0d_line%0d_data", tag, vecs[i].dut, vecs[i].line), 64'(d), 64'(vecs[i].data));
         end else begin
            check($sformatf("%s_dut%0d_line%0d_present", tag, vecs[i].dut, vecs[i].line), 64'(sz), 64'(vecs[i].line + 1));
         end
      end
      check({tag, "_dut0_writes"}, 64'(qa_addr.size()), 64'd8);
      check({tag, "_dut1_writes"}, 64'(qb_addr.size()), 64'd11);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int found;
      int saved_a, saved_b, saved_fsm;

      vecs[0]  = '{0, 0,  32'd0,  32'h03020100};
      vecs[1]  = '{0, 1,  32'd1,  32'h07060504};
      vecs[2]  = '{0, 2,  32'd2,  32'h0B0A0908};
      vecs[3]  = '{0, 3,  32'd3,  32'h0F0E0D0C};
      vecs[4]  = '{0, 4,  32'd4,  32'h13121110};
      vecs[5]  = '{0, 5,  32'd5,  32'h17161514};
      vecs[6]  = '{0, 6,  32'd6,  32'h1B1A1918};
      vecs[7]  = '{0, 7,  32'd7,  32'h1F1E1D1C};
      vecs[8]  = '{1, 0,  32'd0,  32'h00020100};
      vecs[9]  = '{1, 1,  32'd1,  32'h00050403};
      vecs[10] = '{1, 9,  32'd9,  32'h001D1C1B};
      vecs[11] = '{1, 10, 32'd10, 32'h00001F1E};

      ifa.load_start = 1'b0;
      ifa.host_valid = 1'b0;
      ifa.host_data  = 8'h00;
      ifa.host_last  = 1'b0;
      ifa.fsm_rdy    = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst_host_ready",   64'(ifa.host_ready),   64'd0);
      check("rst_mem_wr_en",    64'(ifa.mem_wr_en),    64'd0);
      check("rst_mem_addr",     64'(ifa.mem_addr),     64'd0);
      check("rst_mem_wr_data",  64'(ifa.mem_wr_data),  64'd0);
      check("rst_inputs_rdy",   64'(ifa.inputs_rdy),   64'd0);
      check("rst_start_fsm",    64'(ifa.start_fsm),    64'd0);
      check("rst_start_matmul", 64'(ifa.start_matmul), 64'd0);
      check("rst_load_err",     64'(ifa.load_err),     64'd0);

      // back-to-back load of 0..31
      ifa.host_valid = 1'b1;
      @(negedge clk);
      ifa.host_valid = 1'b0;
      check("idle_ignores_valid", 64'(qa_addr.size()), 64'd0);
      pulse_load_start();
      check("load_host_ready", 64'(ifa.host_ready), 64'd1);
      for (int i = 0; i < 32; i++) send_word(8'(i), i == 31);
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         if (ifa.start_fsm === 1'b1) found = 1;
         else @(negedge clk);
      end
      check("kick_start_fsm_seen", 64'(found), 64'd1);
      check("kick_inputs_rdy",     64'(ifa.inputs_rdy), 64'd1);
      ifa.fsm_rdy = 1'b0;
      repeat (20) @(negedge clk);
      verify_table("seq");
      check("wait_no_matmul", 64'(n_start_matmul), 64'd0);
      check("wait_one_fsm",   64'(n_start_fsm),    64'd1);
      ifa.fsm_rdy = 1'b1;
      check("pre_matmul_low", 64'(ifa.start_matmul), 64'd0);
      @(negedge clk);
      ifa.fsm_rdy = 1'b0;
      check("matmul_pulse", 64'(ifa.start_matmul), 64'd1);
      @(negedge clk);
      check("matmul_single", 64'(ifa.start_matmul), 64'd0);
      check("matmul_count",  64'(n_start_matmul),   64'd1);
      check("done_inputs_rdy", 64'(ifa.inputs_rdy), 64'd1);

      // reload from DONE with gapped valid, a stray load_start, and fsm_rdy already high at KICK
      pulse_load_start();
      check("reload_inputs_rdy", 64'(ifa.inputs_rdy), 64'd0);
      check("reload_mem_addr",   64'(ifa.mem_addr),   64'd0);
      clear_queues();
      for (int i = 0; i < 32; i++) begin
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         if (i == 11) pulse_load_start();
         if (i == 31) ifa.fsm_rdy = 1'b1;
         send_word(8'(i), i == 31);
      end
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         if (ifa.start_matmul === 1'b1) found = 1;
         else @(negedge clk);
      end
      check("early_rdy_matmul_seen", 64'(found), 64'd1);
      ifa.fsm_rdy = 1'b0;
      repeat (2) @(negedge clk);
      verify_table("gap");
      check("gap_matmul_count", 64'(n_start_matmul), 64'd2);

      // early host_last on word 5
      pulse_load_start();
      clear_queues();
      for (int i = 0; i < 6; i++) send_word(8'(i), i == 5);
      check("err_load_err",   64'(ifa.load_err),   64'd1);
      check("err_inputs_rdy", 64'(ifa.inputs_rdy), 64'd0);
      @(negedge clk);
      check("err_writes",     64'(qa_addr.size()), 64'd2);
      if (qa_data.size() >= 2) begin
         check("err_partial_data", 64'(qa_data[1]), 64'h0000_0504);
         check("err_partial_addr", 64'(qa_addr[1]), 64'd1);
      end
      pulse_load_start();
      repeat (3) @(negedge clk);
      check("err_ignores_start", 64'(ifa.host_ready), 64'd0);
      check("err_sticky",        64'(ifa.load_err),   64'd1);
      check("err_no_start_fsm",  64'(n_start_fsm),    64'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("err_rst_clears", 64'(ifa.load_err), 64'd0);

      // word N-1 without host_last
      pulse_load_start();
      clear_queues();
      for (int i = 0; i < 32; i++) send_word(8'(i), 1'b0);
      @(negedge clk);
      check("nolast_load_err",   64'(ifa.load_err),   64'd1);
      check("nolast_inputs_rdy", 64'(ifa.inputs_rdy), 64'd0);
      check("nolast_writes",     64'(qa_addr.size()), 64'd8);
      repeat (3) @(negedge clk);
      check("nolast_no_start_fsm", 64'(n_start_fsm), 64'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // reset after 10 words abandons the load
      pulse_load_start();
      clear_queues();
      for (int i = 0; i < 10; i++) send_word(8'(i), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_mem_wr_en",   64'(ifa.mem_wr_en),   64'd0);
      check("midrst_host_ready",  64'(ifa.host_ready),  64'd0);
      check("midrst_mem_addr",    64'(ifa.mem_addr),    64'd0);
      check("midrst_mem_wr_data", 64'(ifa.mem_wr_data), 64'd0);
      check("midrst_inputs_rdy",  64'(ifa.inputs_rdy),  64'd0);
      check("midrst_load_err",    64'(ifa.load_err),    64'd0);
      saved_a   = qa_addr.size();
      saved_b   = qb_addr.size();
      saved_fsm = n_start_fsm;
      rst = 1'b0;
      ifa.host_valid = 1'b1;
      ifa.host_data  = 8'hAA;
      repeat (10) @(negedge clk);
      ifa.host_valid = 1'b0;
      check("midrst_writes_before", 64'(saved_a), 64'd2);
      check("midrst_no_more_wr_a",  64'(qa_addr.size()), 64'(saved_a));
      check("midrst_no_more_wr_b",  64'(qb_addr.size()), 64'(saved_b));
      check("midrst_no_start_fsm",  64'(n_start_fsm),     64'(saved_fsm));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
